alu_operand_issue: RTL and testbench

- ID/EX issue stage that feeds the ALU: registers decoded operands, then drives ALUoprand1, ALUoprand2 and ALUOP into the ALU each cycle.
- Resolves RAW hazards. It forwards from EX/MEM and MEM/WB, and it stalls IF/ID (inserting bubbles) for load-use or unforwardable hazards.
- Sits between the decode stage and the ALU in the pipelined processor. It accepts a flush from branch resolution.

---
 rtl/alu_operand_issue.sv | 123 ++++++++++++
 tb/tb_alu_operand_issue.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_issue.sv
// ID/EX issue stage: registers decoded operands, forwards producer results into the ALU operands, and raises stall for RAW hazards.
// Optional macro ALU_FORWARDING_EN: when defined, EX/MEM and MEM/WB forwarding is enabled and only load-use hazards stall.
module alu_operand_issue #(
  parameter int XLEN    = 32,
  parameter int REGADDR = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [REGADDR-1:0] id_rs1,
  input  logic [REGADDR-1:0] id_rs2,
  input  logic [REGADDR-1:0] id_rd,
  input  logic [XLEN-1:0]    id_rs1_data,
  input  logic [XLEN-1:0]    id_rs2_data,
  input  logic [XLEN-1:0]    id_imm,
  input  logic               id_alusrc,
  input  logic [2:0]         id_aluop,
  input  logic               id_memread,
  input  logic               id_memwrite,
  input  logic               id_regwrite,
  input  logic               flush,
  input  logic [REGADDR-1:0] exmem_rd,
  input  logic               exmem_regwrite,
  input  logic [XLEN-1:0]    exmem_result,
  input  logic [REGADDR-1:0] memwb_rd,
  input  logic               memwb_regwrite,
  input  logic [XLEN-1:0]    memwb_data,
  output logic               stall,
  output logic [XLEN-1:0]    ALUoprand1,
  output logic [XLEN-1:0]    ALUoprand2,
  output logic [2:0]         ALUOP,
  output logic               ex_valid,
  output logic               ex_memread,
  output logic               ex_memwrite,
  output logic               ex_regwrite,
  output logic [REGADDR-1:0] ex_rd,
  output logic [XLEN-1:0]    ex_store_data
);

  logic [REGADDR-1:0] ex_rs1;
  logic [REGADDR-1:0] ex_rs2;
  logic [XLEN-1:0]    ex_rs1_data;
  logic [XLEN-1:0]    ex_rs2_data;
  logic [XLEN-1:0]    ex_imm;
  logic               ex_alusrc;
  logic               stall_raw;
  logic               bubble;
  logic               id_use2;
  logic [XLEN-1:0]    fwd_rs2;

  // True when a producer writing rd feeds a source the decoding instruction really reads; x0 never matches.
  function automatic logic reads(input logic we, input logic [REGADDR-1:0] rd,
                                 input logic [REGADDR-1:0] rs1, input logic [REGADDR-1:0] rs2,
                                 input logic use2);
    return we && (rd != '0) && ((rd == rs1) || (use2 && (rd == rs2)));
  endfunction

  assign id_use2 = ~id_alusrc | id_memwrite;
  assign bubble  = stall | flush | ~id_valid;
  assign stall   = rst_n & stall_raw;

`ifdef ALU_FORWARDING_EN
  assign stall_raw = id_valid & reads(ex_valid & ex_memread, ex_rd, id_rs1, id_rs2, id_use2);

  // EX/MEM has priority over MEM/WB because it holds the younger result.
  always_comb begin
    ALUoprand1 = ex_rs1_data;
    if ((ex_rs1 != '0) && exmem_regwrite && (exmem_rd == ex_rs1))
      ALUoprand1 = exmem_result;
    else if ((ex_rs1 != '0) && memwb_regwrite && (memwb_rd == ex_rs1))
      ALUoprand1 = memwb_data;
    fwd_rs2 = ex_rs2_data;
    if ((ex_rs2 != '0) && exmem_regwrite && (exmem_rd == ex_rs2))
      fwd_rs2 = exmem_result;
    else if ((ex_rs2 != '0) && memwb_regwrite && (memwb_rd == ex_rs2))
      fwd_rs2 = memwb_data;
  end
`else
  // Without forwarding, every in-flight producer of a used source holds decode until written back.
  assign stall_raw = id_valid & (reads(ex_valid & ex_regwrite, ex_rd, id_rs1, id_rs2, id_use2) |
                                 reads(exmem_regwrite, exmem_rd, id_rs1, id_rs2, id_use2) |
                                 reads(memwb_regwrite, memwb_rd, id_rs1, id_rs2, id_use2));
  assign ALUoprand1 = ex_rs1_data;
  assign fwd_rs2    = ex_rs2_data;

  logic unused_fwd;
  assign unused_fwd = ^{exmem_result, memwb_data, ex_rs1, ex_rs2};
`endif

  assign ALUoprand2    = ex_alusrc ? ex_imm : fwd_rs2;
  assign ex_store_data = fwd_rs2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || bubble) begin
      ex_valid    <= 1'b0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_alusrc   <= 1'b0;
      ALUOP       <= 3'b000;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_regwrite <= 1'b0;
    end else begin
      ex_valid    <= 1'b1;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
      ex_rs1_data <= id_rs1_data;
      ex_rs2_data <= id_rs2_data;
      ex_imm      <= id_imm;
      ex_alusrc   <= id_alusrc;
      ALUOP       <= id_aluop;
      ex_memread  <= id_memread;
      ex_memwrite <= id_memwrite;
      ex_regwrite <= id_regwrite;
    end
  end

endmodule

// File: tb/tb_alu_operand_issue.sv
// Self-checking bench for alu_operand_issue: directed hazard scenarios plus random traffic against a pipeline-level model.
module tb_alu_operand_issue;
  localparam int XLEN = 32;
  localparam int RA   = 5;
  localparam int OW   = 1 + 3 + 4 + RA + 3 * XLEN;
  localparam logic [XLEN-1:0] LOAD_VAL = 32'h0000_00A5;
`ifdef ALU_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam int RAW_STALLS = FWD ? 0 : 3;
  localparam int LU_STALLS  = FWD ? 1 : 3;

  typedef struct packed {
    logic            valid;
    logic [RA-1:0]   rs1, rs2, rd;
    logic [XLEN-1:0] d1, d2, imm;
    logic            alusrc;
    logic [2:0]      op;
    logic            mr, mw, rw, flush;
  } instr_t;

  typedef struct packed {
    logic            we;
    logic [RA-1:0]   rd;
    logic [XLEN-1:0] val;
  } prod_t;

  logic clk, rst_n;
  logic id_valid, id_alusrc, id_memread, id_memwrite, id_regwrite, flush;
  logic [RA-1:0] id_rs1, id_rs2, id_rd, exmem_rd, memwb_rd;
  logic [XLEN-1:0] id_rs1_data, id_rs2_data, id_imm, exmem_result, memwb_data;
  logic [2:0] id_aluop;
  logic exmem_regwrite, memwb_regwrite;
  logic stall, ex_valid, ex_memread, ex_memwrite, ex_regwrite;
  logic [XLEN-1:0] ALUoprand1, ALUoprand2, ex_store_data;
  logic [2:0] ALUOP;
  logic [RA-1:0] ex_rd;

  alu_operand_issue #(.XLEN(XLEN), .REGADDR(RA)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_alusrc(id_alusrc), .id_aluop(id_aluop), .id_memread(id_memread),
    .id_memwrite(id_memwrite), .id_regwrite(id_regwrite), .flush(flush),
    .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite), .exmem_result(exmem_result),
    .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite), .memwb_data(memwb_data),
    .stall(stall), .ALUoprand1(ALUoprand1), .ALUoprand2(ALUoprand2), .ALUOP(ALUOP),
    .ex_valid(ex_valid), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_regwrite(ex_regwrite), .ex_rd(ex_rd), .ex_store_data(ex_store_data)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Model state: register file, instruction in EX, downstream producers
  logic [XLEN-1:0] regs [32];
  instr_t cur, ex_m;
  prod_t pexm, pmwb;
  int prod_mode;            // 0 = pipeline emulation, 1 = random producers, 2 = held producers
  logic [XLEN-1:0] lst_op1, lst_op2;
  bit lst_stall;
  int checks, errors;
  logic [OW-1:0] exp_q[$];
  event chk_ev;

  function automatic logic [XLEN-1:0] alu(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b101:  return {31'b0, $signed(a) < $signed(b)};
      default: return '0;
    endcase
  endfunction

  function automatic bit needs(input instr_t i, input prod_t p);
    return p.we && (p.rd != 0) && ((p.rd == i.rs1) || ((p.rd == i.rs2) && (!i.alusrc || i.mw)));
  endfunction

  function automatic bit model_stall();
    prod_t inflight[$];
    prod_t exp_p;
    if (!cur.valid) return 1'b0;
    exp_p.rd  = ex_m.rd;
    exp_p.val = '0;
    if (FWD) begin
      exp_p.we = ex_m.valid && ex_m.mr;
      return needs(cur, exp_p);
    end
    exp_p.we = ex_m.valid && ex_m.rw;
    inflight.push_back(exp_p);
    inflight.push_back(pexm);
    inflight.push_back(pmwb);
    foreach (inflight[k]) if (needs(cur, inflight[k])) return 1'b1;
    return 1'b0;
  endfunction

  // Value a source sees in EX: youngest forwardable producer, else the register-file read.
  function automatic logic [XLEN-1:0] src(input logic [RA-1:0] rs, input logic [XLEN-1:0] d);
    if (FWD && rs != 0 && pexm.we && pexm.rd == rs) return pexm.val;
    if (FWD && rs != 0 && pmwb.we && pmwb.rd == rs) return pmwb.val;
    return d;
  endfunction

  // Scoreboard
  always @(chk_ev) begin
    logic [OW-1:0] exp_v, act_v;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {stall, ALUOP, ex_valid, ex_memread, ex_memwrite, ex_regwrite, ex_rd,
               ALUoprand1, ALUoprand2, ex_store_data};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL cycle_outputs @%0t: got %h expected %h", $time, act_v, exp_v);
      end
    end
  end

  // Driver tasks
  task automatic drive();
    id_valid = cur.valid; id_rs1 = cur.rs1; id_rs2 = cur.rs2; id_rd = cur.rd;
    id_rs1_data = cur.d1; id_rs2_data = cur.d2; id_imm = cur.imm; id_alusrc = cur.alusrc;
    id_aluop = cur.op; id_memread = cur.mr; id_memwrite = cur.mw; id_regwrite = cur.rw;
    flush = cur.flush;
    exmem_regwrite = pexm.we; exmem_rd = pexm.rd; exmem_result = pexm.val;
    memwb_regwrite = pmwb.we; memwb_rd = pmwb.rd; memwb_data = pmwb.val;
  endtask

  task automatic present(output bit st);
    logic [XLEN-1:0] e_st;
    if (prod_mode == 1) begin
      pexm.we = 1'($urandom_range(0, 1)); pexm.rd = RA'($urandom_range(0, 3)); pexm.val = $urandom;
      pmwb.we = 1'($urandom_range(0, 1)); pmwb.rd = RA'($urandom_range(0, 3)); pmwb.val = $urandom;
    end
    cur.d1 = regs[cur.rs1];
    cur.d2 = regs[cur.rs2];
    drive();
    #2;
    lst_stall = model_stall();
    lst_op1 = src(ex_m.rs1, ex_m.d1);
    e_st = src(ex_m.rs2, ex_m.d2);
    lst_op2 = ex_m.alusrc ? ex_m.imm : e_st;
    exp_q.push_back({lst_stall, ex_m.op, ex_m.valid, ex_m.mr, ex_m.mw, ex_m.rw, ex_m.rd,
                     lst_op1, lst_op2, e_st});
    -> chk_ev;
    #0;
    st = lst_stall;
  endtask

  task automatic advance();
    prod_t nexm;
    @(posedge clk);
    nexm.we  = ex_m.valid && ex_m.rw;
    nexm.rd  = ex_m.rd;
    nexm.val = ex_m.mr ? LOAD_VAL : alu(ex_m.op, lst_op1, lst_op2);
    if (prod_mode == 0) begin
      if (pmwb.we && pmwb.rd != 0) regs[pmwb.rd] = pmwb.val;
      pmwb = pexm;
      pexm = nexm;
    end
    ex_m = (lst_stall || cur.flush || !cur.valid) ? instr_t'('0) : cur;
    @(negedge clk);
  endtask

  task automatic drain();
    bit st;
    prod_mode = 0;
    cur = '0;
    repeat (4) begin present(st); advance(); end
  endtask

  // Presents cur until it issues; returns number of stalled cycles.
  task automatic issue(output int n);
    bit st, done;
    n = 0; done = 0;
    for (int k = 0; k < 8 && !done; k++) begin
      present(st);
      if (k > 0) begin
        checks++;
        if (ex_valid !== 1'b0) begin
          errors++;
          $display("FAIL stall_bubble: ex_valid got %b expected 0", ex_valid);
        end
      end
      advance();
      if (st) n++; else done = 1;
    end
    if (!done) begin
      errors++;
      $display("FAIL issue_timeout: instruction still stalled after %0d cycles", n);
    end
  endtask

  // Tests
  task automatic test_reset();
    rst_n = 1'b0;
    cur = '0; cur.valid = 1; cur.rs1 = 1; cur.rw = 1; cur.rd = 2;
    pexm = '{we: 1'b1, rd: 5'd1, val: 32'h1111};
    pmwb = '{we: 1'b1, rd: 5'd1, val: 32'h2222};
    drive();
    #3;
    checks++;
    if ({stall, ex_valid, ALUOP, ex_rd, ALUoprand1, ALUoprand2} !== '0) begin
      errors++;
      $display("FAIL reset_state: stall=%b ex_valid=%b ALUOP=%b ex_rd=%0d op1=%h op2=%h expected all 0",
               stall, ex_valid, ALUOP, ex_rd, ALUoprand1, ALUoprand2);
    end
    ex_m = '0; pexm = '0; pmwb = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_exmem_forward();
    int n;
    bit st;
    drain();
    regs[1] = 2; regs[3] = 3; regs[4] = 4; regs[5] = 0; regs[6] = 0;
    cur = '0; cur.valid = 1; cur.rs1 = 3; cur.rs2 = 4; cur.rd = 5; cur.rw = 1; cur.op = 3'b000;
    present(st); advance();
    cur = '0; cur.valid = 1; cur.rs1 = 5; cur.rs2 = 1; cur.rd = 6; cur.rw = 1; cur.op = 3'b001;
    issue(n);
    cur = '0;
    present(st);
    checks++;
    if (n != RAW_STALLS) begin errors++; $display("FAIL raw_stall_count: got %0d expected %0d", n, RAW_STALLS); end
    checks++;
    if (ALUoprand1 !== 32'd7) begin errors++; $display("FAIL exmem_fwd_op1: got %h expected %h", ALUoprand1, 32'd7); end
    checks++;
    if (ALUoprand2 !== 32'd2) begin errors++; $display("FAIL exmem_fwd_op2: got %h expected %h", ALUoprand2, 32'd2); end
    checks++;
    if (ALUOP !== 3'b001) begin errors++; $display("FAIL exmem_fwd_aluop: got %b expected 001", ALUOP); end
    advance();
  endtask

  task automatic test_priority();
    bit st;
    drain();
    prod_mode = 2;
    regs[7] = 32'h33;
    pexm = '{we: 1'b1, rd: 5'd7, val: 32'h10};
    pmwb = '{we: 1'b1, rd: 5'd7, val: 32'h20};
    cur = '0; cur.valid = 1; cur.rs1 = 7; cur.alusrc = 1; cur.imm = 1; cur.op = 3'b011; cur.rd = 10; cur.rw = 1;
    present(st); advance();
    cur = '0;
    present(st);
`ifdef ALU_FORWARDING_EN
    checks++;
    if (ALUoprand1 !== 32'h10) begin errors++; $display("FAIL fwd_priority: got %h expected %h", ALUoprand1, 32'h10); end
`endif
    advance();
    pexm = '0; pmwb = '0;
  endtask

  task automatic test_load_use();
    int n;
    bit st;
    drain();
    regs[3] = 32'h0F; regs[8] = 0;
    cur = '0; cur.valid = 1; cur.rs1 = 0; cur.alusrc = 1; cur.imm = 32'h40; cur.mr = 1; cur.rw = 1; cur.rd = 8;
    present(st); advance();
    cur = '0; cur.valid = 1; cur.rs1 = 8; cur.rs2 = 3; cur.rd = 9; cur.rw = 1; cur.op = 3'b010;
    issue(n);
    cur = '0;
    present(st);
    checks++;
    if (n != LU_STALLS) begin errors++; $display("FAIL load_use_stalls: got %0d expected %0d", n, LU_STALLS); end
    checks++;
    if (ALUoprand1 !== LOAD_VAL) begin errors++; $display("FAIL load_use_op1: got %h expected %h", ALUoprand1, LOAD_VAL); end
    checks++;
    if (ALUOP !== 3'b010) begin errors++; $display("FAIL load_use_aluop: got %b expected 010", ALUOP); end
    advance();
  endtask

  task automatic test_x0_flush();
    bit st;
    drain();
    prod_mode = 2;
    regs[0] = 32'h55;
    pexm = '{we: 1'b1, rd: 5'd0, val: 32'hDEAD_BEEF};
    pmwb = '{we: 1'b1, rd: 5'd0, val: 32'h1234};
    cur = '0; cur.valid = 1; cur.rd = 11; cur.rw = 1;
    present(st);
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL x0_no_stall: got %b expected 0", stall); end
    advance();
    cur = '0; cur.valid = 1; cur.flush = 1; cur.rs1 = 2; cur.rd = 12; cur.rw = 1;
    present(st);
    checks++;
    if (ALUoprand1 !== 32'h55 || ALUoprand2 !== 32'h55) begin
      errors++;
      $display("FAIL x0_no_forward: got op1=%h op2=%h expected 55/55", ALUoprand1, ALUoprand2);
    end
    advance();
    cur = '0;
    present(st);
    checks++;
    if (ex_valid !== 1'b0 || ex_regwrite !== 1'b0) begin
      errors++;
      $display("FAIL flush_bubble: got ex_valid=%b ex_regwrite=%b expected 0/0", ex_valid, ex_regwrite);
    end
    advance();
    pexm = '0; pmwb = '0;
  endtask

  task automatic test_reset_midstream();
    bit st;
    drain();
    cur = '0; cur.valid = 1; cur.rd = 3; cur.rw = 1; cur.mr = 1; cur.op = 3'b101;
    present(st); advance();
    cur = '0; cur.valid = 1; cur.rs1 = 3; cur.rd = 4; cur.rw = 1;
    present(st);
    checks++;
    if (ex_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid: got %b expected 1", ex_valid); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({stall, ex_valid, ALUOP, ex_regwrite, ex_memread, ex_rd, ALUoprand1, ALUoprand2} !== '0) begin
      errors++;
      $display("FAIL midstream_reset: stall=%b ex_valid=%b ALUOP=%b rw=%b mr=%b rd=%0d op1=%h op2=%h expected all 0",
               stall, ex_valid, ALUOP, ex_regwrite, ex_memread, ex_rd, ALUoprand1, ALUoprand2);
    end
    ex_m = '0; pexm = '0; pmwb = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    bit st;
    logic [2:0] ops [6];
    ops = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101, 3'b100};
    for (int c = 0; c < 400; c++) begin
      prod_mode = $urandom_range(0, 1);
      cur = '0;
      cur.valid  = ($urandom_range(0, 7) != 0);
      cur.rs1    = RA'($urandom_range(0, 3));
      cur.rs2    = RA'($urandom_range(0, 3));
      cur.rd     = RA'($urandom_range(0, 3));
      cur.imm    = $urandom;
      cur.alusrc = 1'($urandom_range(0, 1));
      cur.op     = ops[$urandom_range(0, 5)];
      cur.mr     = ($urandom_range(0, 3) == 0);
      cur.mw     = ($urandom_range(0, 7) == 0);
      cur.rw     = 1'($urandom_range(0, 1));
      cur.flush  = ($urandom_range(0, 7) == 0);
      present(st);
      advance();
    end
    prod_mode = 0;
  endtask

  initial begin
    checks = 0; errors = 0; prod_mode = 0;
    foreach (regs[i]) regs[i] = $urandom;
    cur = '0; ex_m = '0; pexm = '0; pmwb = '0;
    test_reset();
    test_exmem_forward();
    test_priority();
    test_load_use();
    test_x0_flush();
    test_reset_midstream();
    test_random();
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
